// File: rtl/tetris_pkg.sv
// -----------------------------------------------------------------------------
// tetris_pkg
// Shared definitions for the placement search engine:
//   - piece ID constants (I, O, T, S, Z, J, L)
//   - 4x4 piece mask lookup indexed by (block, rotation)
//   - search FSM state enum
//   - cost weights used by the board scorer
// Mask encoding: bit 4*k + j is row k (0 = top), column j (0 = left) of the
// 4x4 box. Every mask is pushed to the top-left corner of its box.
// -----------------------------------------------------------------------------
package tetris_pkg;

    localparam logic [3:0] PIECE_I = 4'd0;
    localparam logic [3:0] PIECE_O = 4'd1;
    localparam logic [3:0] PIECE_T = 4'd2;
    localparam logic [3:0] PIECE_S = 4'd3;
    localparam logic [3:0] PIECE_Z = 4'd4;
    localparam logic [3:0] PIECE_J = 4'd5;
    localparam logic [3:0] PIECE_L = 4'd6;

    localparam int HOLE_WEIGHT  = 8;
    localparam int LINE_WEIGHT  = 16;
    localparam int TARGET_LINES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAND,
        ST_DROP,
        ST_SCORE,
        ST_RESP
    } state_e;

    function automatic logic piece_legal(input logic [3:0] block);
        return block <= PIECE_L;
    endfunction

    // Rotations advance clockwise; I, S and Z repeat with period 2, O is fixed.
    function automatic logic [15:0] piece_mask(input logic [3:0] block,
                                               input logic [1:0] rot);
        logic [15:0] m;
        m = 16'h0000;
        case (block)
            PIECE_I: m = rot[0] ? 16'h1111 : 16'h000F;
            PIECE_O: m = 16'h0033;
            PIECE_T: begin
                case (rot)
                    2'd0:    m = 16'h0072;
                    2'd1:    m = 16'h0131;
                    2'd2:    m = 16'h0027;
                    default: m = 16'h0232;
                endcase
            end
            PIECE_S: m = rot[0] ? 16'h0231 : 16'h0036;
            PIECE_Z: m = rot[0] ? 16'h0132 : 16'h0063;
            PIECE_J: begin
                case (rot)
                    2'd0:    m = 16'h0071;
                    2'd1:    m = 16'h0113;
                    2'd2:    m = 16'h0047;
                    default: m = 16'h0322;
                endcase
            end
            PIECE_L: begin
                case (rot)
                    2'd0:    m = 16'h0074;
                    2'd1:    m = 16'h0311;
                    2'd2:    m = 16'h0017;
                    default: m = 16'h0223;
                endcase
            end
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/drop_evaluator.sv
// -----------------------------------------------------------------------------
// drop_evaluator
// Purely combinational view of one candidate placement on the latched board.
// Ports:
//   board_i     latched occupancy, cell (r,c) = bit COLS*r + c
//   mask_i      4x4 piece mask for the current rotation
//   row_i       current top row of the piece box
//   anchor_i    current left column of the piece box
//   col_oob_o   some mask cell lies right of the last column
//   hit_here_o  piece overlaps the board (or the floor) at row_i
//   hit_next_o  piece cannot move down to row_i + 1
//   cost_o      cost of the board with the piece merged at row_i (saturating)
// -----------------------------------------------------------------------------
module drop_evaluator
    import tetris_pkg::*;
#(
    parameter int COLS    = 10,
    parameter int ROWS    = 20,
    parameter int SCORE_W = 16,
    parameter int ROW_W   = 5,
    parameter int COL_W   = 4
) (
    input  logic [COLS*ROWS-1:0] board_i,
    input  logic [15:0]          mask_i,
    input  logic [ROW_W-1:0]     row_i,
    input  logic [COL_W-1:0]     anchor_i,
    output logic                 col_oob_o,
    output logic                 hit_here_o,
    output logic                 hit_next_o,
    output logic [SCORE_W-1:0]   cost_o
);

    localparam longint SCORE_MAX = (longint'(1) << SCORE_W) - 1;

    logic [COLS*ROWS-1:0] merged;

    // Bounds and collision checks over the 16 mask cells.
    always_comb begin
        int c;
        int rh;
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment; otherwise synthesis infers a latch.
        col_oob_o  = 1'b0;
        hit_here_o = 1'b0;
        hit_next_o = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                c  = int'(anchor_i) + j;
                rh = int'(row_i) + k;
                if (mask_i[4*k+j]) begin
                    if (c >= COLS) begin
                        col_oob_o = 1'b1;
                    end else begin
                        if (rh >= ROWS)
                            hit_here_o = 1'b1;
                        else if (board_i[rh*COLS+c])
                            hit_here_o = 1'b1;
                        if (rh + 1 >= ROWS)
                            hit_next_o = 1'b1;
                        else if (board_i[(rh+1)*COLS+c])
                            hit_next_o = 1'b1;
                    end
                end
            end
        end
    end

    // Board with the piece merged at (row_i, anchor_i). Mask cells that fall
    // outside the board are dropped; such candidates are never scored.
    always_comb begin
        int k;
        int j;
        merged = board_i;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                k = r - int'(row_i);
                j = c - int'(anchor_i);
                if (k >= 0 && k < 4 && j >= 0 && j < 4) begin
                    if (mask_i[4*k+j])
                        merged[r*COLS+c] = 1'b1;
                end
            end
        end
    end

    // Scoring: holes, stack height and full rows on the merged board, before
    // any line clear. More than TARGET_LINES full rows earns no extra credit.
    always_comb begin
        int  holes;
        int  lines;
        int  top;
        int  raw;
        logic full;
        logic seen;
        holes = 0;
        lines = 0;
        top   = ROWS;
        full  = 1'b0;
        seen  = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            full = 1'b1;
            for (int c = 0; c < COLS; c++) begin
                if (!merged[r*COLS+c])
                    full = 1'b0;
            end
            if (full)
                lines = lines + 1;
        end
        for (int c = 0; c < COLS; c++) begin
            seen = 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                if (merged[r*COLS+c]) begin
                    seen = 1'b1;
                    if (r < top)
                        top = r;
                end else if (seen) begin
                    holes = holes + 1;
                end
            end
        end
        raw = HOLE_WEIGHT * holes + (ROWS - top);
        if (lines < TARGET_LINES)
            raw = raw + LINE_WEIGHT * (TARGET_LINES - lines);
        if (longint'(raw) > SCORE_MAX)
            cost_o = '1;
        else
            cost_o = SCORE_W'(raw);
    end

endmodule

// File: rtl/placement_search.sv
// -----------------------------------------------------------------------------
// placement_search
// Exhaustive placement search for one Tetris piece. A request latches the
// board and piece; every (rotation, left anchor) pair is tried in order
// rotation 0..3 outer, anchor 0..COLS-1 inner. Legal candidates are dropped
// one row per cycle, scored, and the cheapest (earliest on ties) is reported
// with a one-cycle resp_from_client pulse.
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   req_to_client       start pulse, sampled only while idle
//   cur_block           piece ID 0..6 (7..15 illegal)
//   cur_board           occupancy, cell (r,c) = bit COLS*r + c, row 0 on top
//   resp_from_client    one-cycle result-valid pulse
//   opt_col             best left anchor column
//   opt_rotation        best rotation
//   opt_score           cost of the best candidate
//   no_fit              no legal candidate, or illegal piece
//   busy                search in progress, through the response cycle
// -----------------------------------------------------------------------------
module placement_search
    import tetris_pkg::*;
#(
    parameter int COLS    = 10,
    parameter int ROWS    = 20,
    parameter int SCORE_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_to_client,
    input  logic [3:0]           cur_block,
    input  logic [COLS*ROWS-1:0] cur_board,
    output logic                 resp_from_client,
    output logic [3:0]           opt_col,
    output logic [1:0]           opt_rotation,
    output logic [SCORE_W-1:0]   opt_score,
    output logic                 no_fit,
    output logic                 busy
);

    localparam int             ROW_W    = $clog2(ROWS);
    localparam int             COL_W    = 4;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    state_e               state_q, state_d;
    logic [COLS*ROWS-1:0] board_q;
    logic                 load_board;
    logic [3:0]           block_q, block_d;
    logic [1:0]           rot_q, rot_d;
    logic [COL_W-1:0]     anchor_q, anchor_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [SCORE_W-1:0]   best_score_q, best_score_d;
    logic [COL_W-1:0]     best_col_q, best_col_d;
    logic [1:0]           best_rot_q, best_rot_d;
    logic                 best_valid_q, best_valid_d;
    logic                 resp_q, resp_d;
    logic [3:0]           opt_col_q, opt_col_d;
    logic [1:0]           opt_rot_q, opt_rot_d;
    logic [SCORE_W-1:0]   opt_score_q, opt_score_d;
    logic                 no_fit_q, no_fit_d;

    logic [15:0]          mask;
    logic                 col_oob;
    logic                 hit_here;
    logic                 hit_next;
    logic [SCORE_W-1:0]   cost;
    logic                 last_cand;
    logic [1:0]           next_rot;
    logic [COL_W-1:0]     next_anchor;

    assign mask        = piece_mask(block_q, rot_q);
    assign last_cand   = (rot_q == 2'd3) && (anchor_q == LAST_COL);
    assign next_anchor = (anchor_q == LAST_COL) ? '0 : anchor_q + 1'b1;
    assign next_rot    = (anchor_q == LAST_COL) ? rot_q + 1'b1 : rot_q;

    drop_evaluator #(
        .COLS    (COLS),
        .ROWS    (ROWS),
        .SCORE_W (SCORE_W),
        .ROW_W   (ROW_W),
        .COL_W   (COL_W)
    ) u_eval (
        .board_i    (board_q),
        .mask_i     (mask),
        .row_i      (row_q),
        .anchor_i   (anchor_q),
        .col_oob_o  (col_oob),
        .hit_here_o (hit_here),
        .hit_next_o (hit_next),
        .cost_o     (cost)
    );

    always_comb begin
        state_d      = state_q;
        load_board   = 1'b0;
        block_d      = block_q;
        rot_d        = rot_q;
        anchor_d     = anchor_q;
        row_d        = row_q;
        best_score_d = best_score_q;
        best_col_d   = best_col_q;
        best_rot_d   = best_rot_q;
        best_valid_d = best_valid_q;
        resp_d       = 1'b0;
        opt_col_d    = opt_col_q;
        opt_rot_d    = opt_rot_q;
        opt_score_d  = opt_score_q;
        no_fit_d     = no_fit_q;

        case (state_q)
            ST_IDLE: begin
                if (req_to_client) begin
                    load_board   = 1'b1;
                    block_d      = cur_block;
                    rot_d        = 2'd0;
                    anchor_d     = '0;
                    row_d        = '0;
                    best_score_d = '1;
                    best_col_d   = '0;
                    best_rot_d   = 2'd0;
                    best_valid_d = 1'b0;
                    state_d      = ST_CAND;
                end
            end

            // row_q is always 0 here: it is cleared on accept and on advance.
            ST_CAND: begin
                if (!piece_legal(block_q)) begin
                    state_d = ST_RESP;
                end else if (col_oob || hit_here) begin
                    // Skipped candidates cost exactly this one cycle.
                    if (last_cand) begin
                        state_d = ST_RESP;
                    end else begin
                        rot_d    = next_rot;
                        anchor_d = next_anchor;
                    end
                end else begin
                    state_d = ST_DROP;
                end
            end

            ST_DROP: begin
                if (hit_next)
                    state_d = ST_SCORE;
                else
                    row_d = row_q + 1'b1;
            end

            ST_SCORE: begin
                // Strict less-than keeps the earliest candidate on ties.
                if (!best_valid_q || cost < best_score_q) begin
                    best_score_d = cost;
                    best_col_d   = anchor_q;
                    best_rot_d   = rot_q;
                    best_valid_d = 1'b1;
                end
                row_d = '0;
                if (last_cand) begin
                    state_d = ST_RESP;
                end else begin
                    rot_d    = next_rot;
                    anchor_d = next_anchor;
                    state_d  = ST_CAND;
                end
            end

            // With no valid candidate the best registers still hold their
            // cleared values (col 0, rotation 0, score all-ones).
            ST_RESP: begin
                resp_d      = 1'b1;
                opt_col_d   = best_col_q;
                opt_rot_d   = best_rot_q;
                opt_score_d = best_score_q;
                no_fit_d    = !best_valid_q;
                state_d     = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            block_q      <= '0;
            rot_q        <= 2'd0;
            anchor_q     <= '0;
            row_q        <= '0;
            best_score_q <= '1;
            best_col_q   <= '0;
            best_rot_q   <= 2'd0;
            best_valid_q <= 1'b0;
            resp_q       <= 1'b0;
            opt_col_q    <= '0;
            opt_rot_q    <= 2'd0;
            opt_score_q  <= '0;
            no_fit_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            block_q      <= block_d;
            rot_q        <= rot_d;
            anchor_q     <= anchor_d;
            row_q        <= row_d;
            best_score_q <= best_score_d;
            best_col_q   <= best_col_d;
            best_rot_q   <= best_rot_d;
            best_valid_q <= best_valid_d;
            resp_q       <= resp_d;
            opt_col_q    <= opt_col_d;
            opt_rot_q    <= opt_rot_d;
            opt_score_q  <= opt_score_d;
            no_fit_q     <= no_fit_d;
        end
    end

    // NOTE: the board snapshot is a wide data store with no reset; it is only
    // read after being loaded by an accepted request.
    always_ff @(posedge clk) begin
        if (load_board)
            board_q <= cur_board;
    end

    assign resp_from_client = resp_q;
    assign opt_col          = opt_col_q;
    assign opt_rotation     = opt_rot_q;
    assign opt_score        = opt_score_q;
    assign no_fit           = no_fit_q;
    assign busy             = (state_q != ST_IDLE) || resp_q;

endmodule

// File: doc/placement_search.md
# placement_search

Parametrised successor to the single-shot placement calculator. On a request it latches a Tetris board and a piece ID, then searches every rotation (0–3) and every left anchor column. For each legal candidate it simulates a row-by-row drop, scores the resulting board, and returns the lowest-cost placement through the same request/response handshake the game controller already uses. It sits between the board-state keeper and the move driver.

## Interface
- COLS, 10, board width in cells (4..16)
- ROWS, 20, board height in cells (4..32)
- SCORE_W, 16, cost width in bits
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req_to_client  input  1  start pulse; sampled only in IDLE
- cur_block  input  4  piece ID: 0 I, 1 O, 2 T, 3 S, 4 Z, 5 J, 6 L; 7..15 illegal
- cur_board  input  COLS*ROWS  occupancy; cell (r,c) = bit COLS*r+c; row 0 top, col 0 left
- resp_from_client  output  1  one-cycle result-valid pulse
- opt_col  output  4  best left anchor column
- opt_rotation  output  2  best rotation
- opt_score  output  SCORE_W  cost of best candidate
- no_fit  output  1  no legal candidate, or illegal piece
- busy  output  1  high from the cycle after an accepted request through the response cycle

## Operation
- Piece masks are 4x4 and left/top aligned: mask bit (k,j) maps to board cell (r+k, anchor+j).
- Candidate order: rotation 0..3 outer, anchor 0..COLS-1 inner.
- FSM states: IDLE, CAND, DROP, SCORE, RESP.
- IDLE: on req_to_client=1, latch board and block; clear best_score to all-ones and best_valid; go to CAND.
  - If block ≥ 7, go straight to RESP with no_fit=1.
- CAND: if any mask cell has anchor+j ≥ COLS, the candidate is skipped. Otherwise set r=0.
  - If the mask collides at r=0, the candidate is skipped (game-over placement).
  - Otherwise go to DROP.
- DROP: one row per cycle.
  - If any mask cell at r+1 would be beyond ROWS-1 or hit an occupied cell, the piece lands at r; go to SCORE.
  - Otherwise r ← r+1.
- SCORE: merge the piece at r and compute, on the merged board before any line clear:
  - holes: empty cells with any filled cell above them in the same column
  - max_h: ROWS minus the index of the topmost occupied row
  - lines: number of full rows
  - cost = 8·holes + max_h + 16·(4−lines), saturating at all-ones of SCORE_W.
  - Strict less-than replaces the best, so on ties the earliest candidate wins.
  - Advance to the next candidate (→ CAND), or to RESP after rotation 3, anchor COLS-1.
- Skipped candidates advance within the same CAND cycle.
- RESP: drive resp_from_client=1 for one cycle. Update opt_col, opt_rotation, opt_score and no_fit (no_fit = !best_valid). Go to IDLE.
- The result outputs hold their values until the next RESP.
- When no_fit=1: opt_col=0, opt_rotation=0, opt_score=all-ones.

## Timing
- Reset values: resp_from_client=0, opt_col=0, opt_rotation=0, opt_score=0, no_fit=0, busy=0; FSM in IDLE.
- Reset mid-search: return to IDLE immediately; no response is emitted.
- req_to_client while busy is ignored, not queued.
- Inputs are sampled only on the accepting edge. Later changes to cur_board or cur_block do not affect the search.
- Per-candidate cycle cost:
  - skipped: 1 cycle
  - legal: 1 (CAND) + drop rows + 1 (SCORE)
- Worst case: 4·COLS·(ROWS+2)+2 cycles, which is 882 for the defaults.
- Illegal piece: resp_from_client rises 2 cycles after the accepting edge.
- One response per accepted request; responses are never back-to-back without an intervening request.

## Structure
- Package tetris_pkg:
  - piece ID constants
  - 4x4 mask lookup function indexed by (block, rotation)
  - FSM state enum
  - cost weights (8, 16)
- Sub-module drop_evaluator: purely combinational. Takes the latched board, mask, r and anchor; returns collision-at-r+1, out-of-bounds flag and cost. The FSM, counters and best-tracking live in placement_search.

## Test plan
- Empty board, block 1 (O) → col 0, rotation 0, opt_score 66, no_fit 0.
- Row 19 filled in cols 0..8, block 0 (I) → col 9, rotation 1, opt_score 52 (lines 1, max_h 4). Rotation 1 wins the tie against rotation 3.
- All 200 cells filled, block 2 → no_fit 1, opt_score 0xFFFF, col 0, rotation 0.
- cur_block=9 → resp_from_client exactly 2 cycles after accept, no_fit 1.
- Second req_to_client during a search → ignored; exactly one response, and busy stays high until it.
- rst asserted mid-DROP → all outputs at reset values, no response pulse. A fresh request then completes normally.
